// File: rtl/reg_file_dump.sv
// reg_file_dump
//   Walks a register file's asynchronous read port from FIRST to LAST (with
//   wrap-around at FILE_DEPTH-1) and presents each word on a valid/ready
//   output stream.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous reset, active low
//   START      one-cycle dump request, honoured only while idle
//   ABORT      terminate a dump in progress (no DONE pulse)
//   FIRST/LAST inclusive address range, sampled with START
//   RA         read address to the register file (driven from the pointer)
//   RD         combinational read data for RA
//   OUT_DATA   captured register value
//   OUT_ADDR   address of OUT_DATA
//   OUT_VALID  OUT_DATA/OUT_ADDR valid
//   OUT_READY  consumer accepts the presented word
//   BUSY       high whenever a dump is in progress
//   DONE       one-cycle pulse after the last word has been accepted
module reg_file_dump #(
    parameter int FILE_WIDTH         = 32,
    parameter int FILE_DEPTH         = 32,
    parameter int FILE_ADDRESS_WIDTH = 5
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic [FILE_ADDRESS_WIDTH-1:0] FIRST,
    input  logic [FILE_ADDRESS_WIDTH-1:0] LAST,
    output logic [FILE_ADDRESS_WIDTH-1:0] RA,
    input  logic [FILE_WIDTH-1:0]         RD,
    output logic [FILE_WIDTH-1:0]         OUT_DATA,
    output logic [FILE_ADDRESS_WIDTH-1:0] OUT_ADDR,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic                          BUSY,
    output logic                          DONE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    localparam logic [FILE_ADDRESS_WIDTH-1:0] PTR_MAX = FILE_ADDRESS_WIDTH'(FILE_DEPTH - 1);

    state_t                          state_q, state_d;
    logic [FILE_ADDRESS_WIDTH-1:0]   ptr_q, ptr_d;
    logic [FILE_ADDRESS_WIDTH-1:0]   end_q, end_d;
    logic [FILE_WIDTH-1:0]           data_q, data_d;
    logic [FILE_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic                            valid_q, valid_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [FILE_ADDRESS_WIDTH-1:0]   ptr_next;

    // Wrap explicitly so non-power-of-two depths also return to 0.
    assign ptr_next = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ptr_d   = FIRST;
                    end_d   = LAST;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ABORT) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    data_d  = RD;
                    addr_d  = ptr_q;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // ABORT wins over a simultaneous handshake.
                if (ABORT) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (OUT_READY) begin
                    valid_d = 1'b0;
                    if (ptr_q == end_q) begin
                        state_d = S_FINISH;
                    end else begin
                        ptr_d   = ptr_next;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // BUSY/DONE are registered copies of the upcoming state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RA        = ptr_q;
    assign OUT_DATA  = data_q;
    assign OUT_ADDR  = addr_q;
    assign OUT_VALID = valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_reg_file_dump.sv
module tb_reg_file_dump;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [4:0]  FIRST = '0;
    logic [4:0]  LAST = '0;
    logic [4:0]  RA;
    logic [31:0] RD;
    logic [31:0] OUT_DATA;
    logic [4:0]  OUT_ADDR;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic        BUSY;
    logic        DONE;

    logic [31:0] regs [32];
    assign RD = regs[RA];

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [36:0] sb [$];   // {addr, data}
    bit          rand_mode = 0;

    always #5 CLK = ~CLK;

    reg_file_dump #(
        .FILE_WIDTH(32),
        .FILE_DEPTH(32),
        .FILE_ADDRESS_WIDTH(5)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .FIRST(FIRST), .LAST(LAST), .RA(RA), .RD(RD),
        .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: inclusive range with modulo-32 wrap, data from the model array.
    task automatic push_range(input int f, input int l);
        int a = f;
        forever begin
            sb.push_back({a[4:0], regs[a]});
            if (a == l) break;
            a = (a + 1) % 32;
        end
    endtask

    // Monitor: pops on every accepted word, checks stability while stalled.
    initial begin : monitor
        bit          prev_hold = 0;
        logic [36:0] prev_word = '0;
        logic [36:0] exp_word;
        forever begin
            @(negedge CLK);
            if (RST && prev_hold)
                chk("hold_stable", {OUT_VALID, OUT_ADDR, OUT_DATA}, {1'b1, prev_word});
            if (RST && OUT_VALID && OUT_READY && !ABORT) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_word: got addr %0d data %0h expected none", OUT_ADDR, OUT_DATA);
                end else begin
                    exp_word = sb.pop_front();
                    chk("word", {OUT_ADDR, OUT_DATA}, exp_word);
                end
            end
            prev_hold = RST && OUT_VALID && !OUT_READY && !ABORT;
            prev_word = {OUT_ADDR, OUT_DATA};
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge CLK);
            #1;
            if (rand_mode) OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_dump(input int f, input int l);
        @(posedge CLK);
        #1;
        FIRST = f[4:0];
        LAST  = l[4:0];
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        FIRST = 5'($urandom);
        LAST  = 5'($urandom);
    endtask

    // Counts negedges after the START-sampling edge until DONE is seen.
    task automatic wait_done(input int bound, output int n, output bit found);
        n = 0;
        found = 0;
        while (n < bound) begin
            @(negedge CLK);
            n++;
            if (DONE) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic after_done();
        @(negedge CLK);
        chk("done_pulse_width", DONE, 1'b0);
        chk("busy_after_done", BUSY, 1'b0);
        chk("queue_drained", sb.size(), 0);
    endtask

    initial begin : stimulus
        int  n;
        bit  found;
        int  guard;
        logic [31:0] orig;

        for (int i = 0; i < 32; i++) regs[i] = i * 32'h1111_1111;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", OUT_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_data", OUT_DATA, 32'h0);
        chk("rst_addr", OUT_ADDR, 5'h0);
        chk("rst_ra", RA, 5'h0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_after_rst", {BUSY, OUT_VALID}, 2'b00);

        // Full dump, ready held high: 32 words, 2 cycles each.
        OUT_READY = 1'b1;
        push_range(0, 31);
        start_dump(0, 31);
        wait_done(200, n, found);
        chk("full_done_seen", found, 1'b1);
        chk("full_latency", n, 65);
        after_done();

        // Wrap-around range.
        push_range(30, 1);
        start_dump(30, 1);
        wait_done(200, n, found);
        chk("wrap_done_seen", found, 1'b1);
        chk("wrap_latency", n, 9);
        after_done();

        // Single word with a long stall and a write to the source register.
        OUT_READY = 1'b0;
        orig = regs[5];
        push_range(5, 5);
        start_dump(5, 5);
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!OUT_VALID && guard < 20);
        chk("stall_valid_seen", OUT_VALID, 1'b1);
        regs[5] = 32'hDEAD_BEEF;
        repeat (10) @(negedge CLK);
        chk("stall_data_held", OUT_DATA, orig);
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        wait_done(50, n, found);
        chk("stall_done_seen", found, 1'b1);
        after_done();
        regs[5] = orig;

        // Abort while address 7 is presented with ready high.
        push_range(0, 6);
        start_dump(0, 31);
        guard = 0;
        forever begin
            @(posedge CLK);
            #1;
            guard++;
            if ((OUT_VALID && OUT_ADDR == 5'd7) || guard > 100) break;
        end
        chk("abort_reached_7", {OUT_VALID, OUT_ADDR}, {1'b1, 5'd7});
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        chk("abort_idle", {BUSY, OUT_VALID, DONE}, 3'b000);
        found = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE || OUT_VALID || BUSY) found = 1;
        end
        chk("abort_quiet", found, 1'b0);
        chk("abort_queue", sb.size(), 0);
        push_range(3, 5);
        start_dump(3, 5);
        wait_done(50, n, found);
        chk("restart_done_seen", found, 1'b1);
        chk("restart_latency", n, 7);
        after_done();

        // Reset mid-dump at address 12.
        push_range(0, 11);
        start_dump(0, 31);
        guard = 0;
        forever begin
            @(posedge CLK);
            #1;
            guard++;
            if ((OUT_VALID && OUT_ADDR == 5'd12) || guard > 100) break;
        end
        chk("rst_reached_12", {OUT_VALID, OUT_ADDR}, {1'b1, 5'd12});
        RST = 1'b0;
        #1;
        chk("midrst_outputs", {OUT_DATA, OUT_ADDR, OUT_VALID, BUSY, DONE, RA},
            {32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0});
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        found = 0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE || OUT_VALID || BUSY) found = 1;
        end
        chk("midrst_stays_idle", found, 1'b0);
        chk("midrst_queue", sb.size(), 0);

        // START pulses while busy are ignored.
        push_range(10, 13);
        start_dump(10, 13);
        @(posedge CLK);
        #1;
        START = 1'b1;
        FIRST = 5'd0;
        LAST  = 5'd0;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(50, n, found);
        chk("busy_start_done_seen", found, 1'b1);
        after_done();
        found = 0;
        repeat (4) begin
            @(negedge CLK);
            if (BUSY || OUT_VALID) found = 1;
        end
        chk("busy_start_no_restart", found, 1'b0);

        // Randomised ranges with random backpressure.
        rand_mode = 1;
        for (int k = 0; k < 8; k++) begin
            int f = $urandom_range(0, 31);
            int l = $urandom_range(0, 31);
            push_range(f, l);
            start_dump(f, l);
            wait_done(1000, n, found);
            chk("rand_done_seen", found, 1'b1);
            @(negedge CLK);
            chk("rand_queue", sb.size(), 0);
        end
        rand_mode = 0;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file_dump.md
REG_FILE_DUMP -- requirements
Module: reg_file_dump

Interface
REQ-001 Parameter FILE_WIDTH, default 32: register word width in bits.
REQ-002 Parameter FILE_DEPTH, default 32: number of registers in the register file being read.
REQ-003 Parameter FILE_ADDRESS_WIDTH, default 5: register address width.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous reset, active low.
REQ-006 START  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 ABORT  input  1  terminate the dump in progress.
REQ-008 FIRST  input  FILE_ADDRESS_WIDTH  first register address; sampled with START.
REQ-009 LAST  input  FILE_ADDRESS_WIDTH  last register address; sampled with START.
REQ-010 RA  output  FILE_ADDRESS_WIDTH  read address to the register file asynchronous read port.
REQ-011 RD  input  FILE_WIDTH  read data returned combinationally for RA.
REQ-012 OUT_DATA  output  FILE_WIDTH  captured register value.
REQ-013 OUT_ADDR  output  FILE_ADDRESS_WIDTH  address of OUT_DATA.
REQ-014 OUT_VALID  output  1  OUT_DATA/OUT_ADDR valid.
REQ-015 OUT_READY  input  1  consumer accepts the word.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 DONE  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-018 States: IDLE, FETCH, PRESENT, FINISH; all outputs registered except RA, which is driven directly from the registered pointer PTR.
REQ-019 IDLE: on START=1, load PTR<=FIRST and END<=LAST, go FETCH; otherwise stay.
REQ-020 FETCH: at the clock edge, capture OUT_DATA<=RD (for RA=PTR) and OUT_ADDR<=PTR, set OUT_VALID<=1, go PRESENT; FETCH lasts exactly one cycle.
REQ-021 PRESENT: OUT_DATA, OUT_ADDR, and OUT_VALID held constant while OUT_READY=0, regardless of changes on RD.
REQ-022 PRESENT with OUT_READY=1 (handshake): OUT_VALID<=0; if PTR==END go FINISH, else PTR<=PTR+1 and go FETCH.
REQ-023 Throughput: one word per two cycles when OUT_READY is held high.
REQ-024 Pointer increment wraps from FILE_DEPTH-1 to 0; FIRST>LAST therefore dumps FIRST..FILE_DEPTH-1 then 0..LAST.
REQ-025 FIRST==LAST dumps exactly one word.
REQ-026 FINISH: DONE=1 for exactly one cycle, then IDLE; BUSY=1 in FINISH.
REQ-027 START in any state other than IDLE is ignored; FIRST/LAST changes after the START cycle have no effect.
REQ-028 ABORT=1 in FETCH or PRESENT: next state IDLE, OUT_VALID<=0, no DONE pulse; ABORT has priority over the handshake in the same cycle. ABORT in IDLE or FINISH has no effect.
REQ-029 A register-file write to the address on RA during FETCH yields the pre-edge RD value (the value visible combinationally in that cycle).
REQ-030 RA in IDLE equals the last PTR value; RA is don't-care to consumers outside FETCH.

Reset
REQ-031 RST=0 asynchronously forces IDLE, PTR=0, END=0, RA=0, OUT_DATA=0, OUT_ADDR=0, OUT_VALID=0, DONE=0, BUSY=0, including mid-dump.
REQ-032 After RST deasserts, the block stays in IDLE until the next START.

Verification
REQ-033 Register file preloaded with reg[i]=i*0x11111111; START, FIRST=0, LAST=31, OUT_READY=1 -> 32 words in order, addr 0..31, data matching, one word every 2 cycles, DONE pulse 1 cycle after word 31 accepted, BUSY low the cycle after that.
REQ-034 FIRST=30, LAST=1, OUT_READY=1 -> addresses 30,31,0,1 exactly, then DONE.
REQ-035 FIRST=LAST=5, OUT_READY low for 10 cycles, reg[5] overwritten with 0xDEADBEEF during the stall -> OUT_DATA holds the original value throughout the stall; one word, then DONE.
REQ-036 Dump 0..31, ABORT asserted in PRESENT of addr 7 with OUT_READY=1 -> addr 7 not accepted, IDLE next cycle, OUT_VALID=0, no DONE; a new START at FIRST=3 dumps from addr 3.
REQ-037 RST pulsed low mid-dump at addr 12 -> all outputs zero immediately (before the next edge); no further words; START pulses during BUSY are ignored (checked in a separate run).
